// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions and
// the fetch-stage FSM state encoding.
package cpu_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LDR   = 5'b00001;
  localparam logic [4:0] OP_STR   = 5'b00010;
  localparam logic [4:0] OP_BEQ   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00100;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int ALU_HI = 26;
  localparam int ALU_LO = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 20;
  localparam int RN_HI  = 19;
  localparam int RN_LO  = 16;
  localparam int RM_HI  = 15;
  localparam int RM_LO  = 12;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic is_legal_op(input logic [4:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LDR, OP_STR, OP_BEQ, OP_ADDI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read channel. imem_req is held with a stable imem_addr
// until the cycle imem_ack is high; imem_rdata is valid only in that cycle.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: reset to RESET_PC, load on redirect, else step on capture.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] target_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, branch redirect with
// squash of in-flight words, and a decode-side output register with stall.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master imem,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  input  logic          id_stall,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic [31:0]   if_pc,
  output logic [4:0]    opcode,
  output logic [2:0]    aluop,
  output logic [3:0]    rd,
  output logic [3:0]    rn,
  output logic [3:0]    rm,
  output logic [15:0]   imm16,
  output logic          illegal,
  output fetch_state_e  dbg_state_o
);

  fetch_state_e state_q, state_d;
  logic         squash_q, squash_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  pc;
  logic         pc_load;
  logic         pc_inc;
  logic         req_c;
  logic [31:0]  addr_c;
  logic         consumed;

  pc_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pc_load),
    .target_i (br_target),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  assign consumed = valid_q && !id_stall;

  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    addr_d   = addr_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    req_c    = 1'b0;
    addr_c   = pc;
    if (consumed) valid_d = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // A stalled, still-valid word must not be overwritten, so no request.
        req_c = !(valid_q && id_stall);
        if (br_taken) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          if (req_c && !imem.imem_ack) begin
            squash_d = 1'b1;
            addr_d   = pc;
            state_d  = ST_WAIT;
          end
        end else if (!req_c) begin
          state_d = ST_HOLD;
        end else if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          ipc_d   = pc;
          valid_d = 1'b1;
          pc_inc  = 1'b1;
        end else begin
          addr_d  = pc;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        req_c  = 1'b1;
        addr_c = addr_q;
        if (imem.imem_ack) begin
          state_d  = ST_FETCH;
          squash_d = 1'b0;
          if (br_taken) begin
            pc_load = 1'b1;
            valid_d = 1'b0;
          end else if (!squash_q) begin
            instr_d = imem.imem_rdata;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            pc_inc  = 1'b1;
          end
        end else if (br_taken) begin
          pc_load  = 1'b1;
          squash_d = 1'b1;
          valid_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        if (br_taken) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end else if (!id_stall) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      squash_q <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      ipc_q    <= 32'h0;
      addr_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      addr_q   <= addr_d;
    end
  end

  assign imem.imem_req  = req_c && !rst;
  assign imem.imem_addr = addr_c;

  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign opcode      = instr_q[OPC_HI:OPC_LO];
  assign aluop       = instr_q[ALU_HI:ALU_LO];
  assign rd          = instr_q[RD_HI:RD_LO];
  assign rn          = instr_q[RN_HI:RN_LO];
  assign rm          = instr_q[RM_HI:RM_LO];
  assign imm16       = instr_q[IMM_HI:IMM_LO];
  assign illegal     = valid_q && !is_legal_op(instr_q[OPC_HI:OPC_LO]);
  assign dbg_state_o = state_q;

endmodule
